// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared state encodings and match pattern for pattern_tx
package pattern_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAPW
    } tx_state_t;

    typedef enum logic [2:0] {
        M_RST,
        M_1,
        M_10,
        M_101,
        M_1011
    } mon_state_t;

    localparam logic [4:0] PATTERN   = 5'b10110;
    localparam logic [7:0] MATCH_MAX = 8'hFF;

endpackage

// File: rtl/pattern_tx_mon.sv
// rtl/pattern_tx_mon.sv - counts non-overlapping 10110 patterns on the emitted stream
module pattern_tx_mon
    import pattern_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic       out,
    output logic [7:0] match_cnt
);

    mon_state_t r_state;
    mon_state_t w_state;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt;
    logic       w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= M_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
        end
    end

    // Each state advances when the bit equals the next pattern bit; otherwise fall back
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_hit   = 1'b0;
        if (valid) begin
            case (r_state)
                M_RST:   w_state = (out == PATTERN[4]) ? M_1    : M_RST;
                M_1:     w_state = (out == PATTERN[3]) ? M_10   : M_1;
                M_10:    w_state = (out == PATTERN[2]) ? M_101  : M_RST;
                M_101:   w_state = (out == PATTERN[1]) ? M_1011 : M_10;
                M_1011: begin
                    w_hit   = (out == PATTERN[0]);
                    w_state = w_hit ? M_RST : M_1;
                end
                default: w_state = M_RST;
            endcase
        end
        if (w_hit && (r_cnt != MATCH_MAX)) begin
            w_cnt = r_cnt + 8'd1;
        end
    end

    assign match_cnt = r_cnt;

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - word-to-serial transmitter with holding register, inter-word gap and pattern monitor
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              valid,
    output logic              out,
    output logic              busy,
    output logic [7:0]        match_cnt
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0]        GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    tx_state_t         r_state;
    tx_state_t         w_state;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_hold;
    logic              r_hold_full;
    logic              w_hold_full;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [CNT_W-1:0]  w_bitcnt;
    logic [3:0]        r_gapcnt;
    logic [3:0]        w_gapcnt;
    logic              r_valid;
    logic              w_valid;
    logic              r_out;
    logic              w_out;
    logic              r_busy;
    logic              w_busy;
    logic              w_take;
    logic              w_accept;

    assign w_accept = load & ~r_hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_gapcnt    <= '0;
            r_valid     <= 1'b0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_hold      <= w_hold;
            r_hold_full <= w_hold_full;
            r_shreg     <= w_shreg;
            r_bitcnt    <= w_bitcnt;
            r_gapcnt    <= w_gapcnt;
            r_valid     <= w_valid;
            r_out       <= w_out;
            r_busy      <= w_busy;
        end
    end

    // r_out carries the bit on the line; r_shreg keeps only the bits still to be sent
    always_comb begin
        w_state     = r_state;
        w_hold      = r_hold;
        w_hold_full = r_hold_full;
        w_shreg     = r_shreg;
        w_bitcnt    = r_bitcnt;
        w_gapcnt    = r_gapcnt;
        w_valid     = 1'b0;
        w_out       = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_full) begin
                    w_take  = 1'b1;
                    w_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_bitcnt == LAST_BIT) begin
                    if (GAP > 0) begin
                        w_state  = S_GAPW;
                        w_gapcnt = '0;
                    end else if (r_hold_full) begin
                        w_take = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_valid  = 1'b1;
                    w_out    = r_shreg[DATA_W-1];
                    w_shreg  = r_shreg << 1;
                    w_bitcnt = r_bitcnt + CNT_W'(1);
                end
            end
            S_GAPW: begin
                if (r_gapcnt == GAP_LAST) begin
                    if (r_hold_full) begin
                        w_take  = 1'b1;
                        w_state = S_SHIFT;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_gapcnt = r_gapcnt + 4'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // A transfer puts the word's MSB on the line in the same edge it leaves hold
        if (w_take) begin
            w_valid     = 1'b1;
            w_out       = r_hold[DATA_W-1];
            w_shreg     = r_hold << 1;
            w_bitcnt    = '0;
            w_hold_full = 1'b0;
        end
        if (w_accept) begin
            w_hold      = data;
            w_hold_full = 1'b1;
        end
        w_busy = (w_state != S_IDLE) || w_hold_full;
    end

    pattern_tx_mon u_mon (
        .clk       (clk),
        .rst       (rst),
        .valid     (r_valid),
        .out       (r_out),
        .match_cnt (match_cnt)
    );

    assign ready = ~r_hold_full;
    assign valid = r_valid;
    assign out   = r_out;
    assign busy  = r_busy;

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - self-checking bench for pattern_tx (GAP=0 and GAP=2 instances)
module tb_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data = '0;
    logic       ready, valid, out, busy;
    logic [7:0] match_cnt;
    logic       g_load = 1'b0;
    logic [7:0] g_data = '0;
    logic       g_ready, g_valid, g_out, g_busy;
    logic [7:0] g_match;

    always #5 clk = ~clk;

    pattern_tx #(.DATA_W(8), .GAP(0)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .ready(ready),
        .valid(valid), .out(out), .busy(busy), .match_cnt(match_cnt)
    );

    pattern_tx #(.DATA_W(8), .GAP(2)) dut_g (
        .clk(clk), .rst(rst), .load(g_load), .data(g_data), .ready(g_ready),
        .valid(g_valid), .out(g_out), .busy(g_busy), .match_cnt(g_match)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected serial stream and a non-overlapping pattern counter over it
    bit exp_q[$];
    bit hist[$];
    int mcount   = 0;
    int cur_run  = 0;
    int last_run = 0;
    bit rst_q    = 1'b1;

    function automatic void model_bit(input bit b);
        hist.push_back(b);
        if (hist.size() > 5) void'(hist.pop_front());
        if (hist.size() == 5 && {hist[0], hist[1], hist[2], hist[3], hist[4]} == 5'b10110) begin
            if (mcount < 255) mcount++;
            hist.delete();
        end
    endfunction

    initial forever begin
        @(posedge clk);
        rst_q = rst;
    end

    initial forever begin
        @(negedge clk);
        if (rst_q) begin
            exp_q.delete();
            hist.delete();
            mcount  = 0;
            cur_run = 0;
            chk("rst_valid", valid, 0);
            chk("rst_out", out, 0);
            chk("rst_ready", ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_match", match_cnt, 0);
        end else begin
            chk("match_cnt", match_cnt, mcount);
            if (valid) begin
                cur_run++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    chk("out_bit", out, e);
                    model_bit(e);
                end
            end else begin
                chk("idle_out", out, 0);
                if (cur_run > 0) last_run = cur_run;
                cur_run = 0;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            chk("send_timeout", 0, 1);
            return;
        end
        load = 1'b1;
        data = d;
        for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic sendg(input logic [7:0] d);
        int n;
        n = 0;
        while (g_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (g_ready !== 1'b1) begin
            chk("sendg_timeout", 0, 1);
            return;
        end
        g_load = 1'b1;
        g_data = d;
        @(negedge clk);
        g_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (exp_q.size() == 0 && valid === 1'b0), 1);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  word;
        logic [15:0] gw;
        int          nv, gv, gz, pend;
        bit          started;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single word: two-cycle latency, MSB first, one match
        send(8'hB6);
        chk("lat_valid_n1", valid, 0);
        chk("lat_ready_n1", ready, 0);
        chk("lat_busy_n1", busy, 1);
        @(negedge clk);
        chk("lat_valid_n2", valid, 1);
        word = '0;
        nv   = 0;
        for (int i = 0; i < 8; i++) begin
            word = {word[6:0], out};
            nv   = nv + int'(valid);
            @(negedge clk);
        end
        chk("w1_bits", word, 8'hB6);
        chk("w1_valid_cnt", nv, 8);
        chk("w1_end_valid", valid, 0);
        chk("w1_match", match_cnt, 1);
        chk("w1_busy", busy, 0);

        // Back-to-back words, plus a load while the holding register is full
        send(8'hB6);
        send(8'h5A);
        chk("b2b_ready_full", ready, 0);
        chk("b2b_busy", busy, 1);
        load = 1'b1;
        data = 8'hFF;
        @(negedge clk);
        load = 1'b0;
        chk("drop_ready", ready, 0);
        drain();
        chk("b2b_run_len", last_run, 16);
        chk("b2b_match", match_cnt, 3);

        // GAP=2 instance: two words separated by exactly two idle cycles
        gw = '0; gv = 0; gz = 0; pend = 0; started = 1'b0;
        fork
            begin
                sendg(8'hB6);
                sendg(8'h5A);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (g_valid) begin
                        gw = {gw[14:0], g_out};
                        gv++;
                        if (started) gz += pend;
                        pend    = 0;
                        started = 1'b1;
                    end else begin
                        chk("g_idle_out", g_out, 0);
                        if (started) pend++;
                    end
                end
            end
        join
        chk("g_bits", gw, 16'hB65A);
        chk("g_valid_cnt", gv, 16);
        chk("g_gap_len", gz, 2);
        chk("g_match", g_match, 2);

        // Reset on bit 4 of a word with a second word held and a colliding load
        send(8'hB6);
        send(8'hB6);
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", valid, 1);
        chk("pre_rst_ready", ready, 0);
        rst  = 1'b1;
        load = 1'b1;
        data = 8'hFF;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        chk("post_rst_valid", valid, 0);
        chk("post_rst_ready", ready, 1);
        chk("post_rst_match", match_cnt, 0);
        repeat (12) @(negedge clk);
        chk("post_rst_quiet", valid, 0);
        chk("post_rst_ready2", ready, 1);

        // Saturation of the match counter
        for (int i = 0; i < 300; i++) send(8'hB6);
        drain();
        chk("sat_match", match_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the parallel word width (range 2..32).
REQ-002 Parameter GAP, default 0, SHALL set the idle cycles (valid low) inserted after each word (range 0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 load  input  1  SHALL be the word strobe, accepted only when ready=1.
REQ-006 data  input  DATA_W  SHALL be the word to transmit, sampled when load&ready.
REQ-007 ready  output  1  SHALL indicate the holding register is empty.
REQ-008 valid  output  1  SHALL qualify out as a live serial bit.
REQ-009 out  output  1  SHALL be the serial bit, MSB of each word first.
REQ-010 busy  output  1  SHALL be high whenever the FSM is not IDLE or the holding register is full.
REQ-011 match_cnt  output  8  SHALL count emitted 10110 patterns, saturating.

Function
REQ-012 Storage SHALL be one holding register (hold, hold_full) plus one shift register (shreg) and a bit counter of width ceil(log2(DATA_W)).
REQ-013 ready SHALL equal !hold_full; load while ready=0 SHALL be ignored with no state change.
REQ-014 FSM states SHALL be IDLE, SHIFT, GAPW; all outputs registered.
REQ-015 IDLE: if hold_full, move hold to shreg, clear hold_full, go SHIFT; else stay.
REQ-016 Word accepted in IDLE at edge N SHALL produce its first valid bit in the cycle after edge N+1 (2-cycle latency).
REQ-017 SHIFT: valid=1, out=shreg MSB, shift left each cycle, for exactly DATA_W consecutive cycles.
REQ-018 After the last bit: GAP>0 -> GAPW; else hold_full -> reload shreg, stay SHIFT (no bubble); else IDLE.
REQ-019 GAPW: valid=0 for exactly GAP cycles, then hold_full -> SHIFT with reload, else IDLE.
REQ-020 Simultaneous load and hold-to-shreg transfer in the same cycle SHALL capture the new word into hold (hold_full stays 1).
REQ-021 When valid=0, out SHALL be 0.
REQ-022 Monitor FSM SHALL track emitted bits on valid=1 only, states M_RST, M_1, M_10, M_101, M_1011: M_RST 1->M_1, 0->M_RST; M_1 1->M_1, 0->M_10; M_10 1->M_101, 0->M_RST; M_101 1->M_1011, 0->M_10; M_1011 1->M_1, 0->M_RST and increment.
REQ-023 match_cnt SHALL update one cycle after the final 0 of a match is emitted and SHALL hold at 255.

Reset
REQ-024 On rst: FSM IDLE, monitor M_RST, hold_full=0, shreg=0, counters=0; outputs valid=0, out=0, ready=1, busy=0, match_cnt=0.
REQ-025 rst mid-word SHALL abort immediately; remaining bits and any held word SHALL be discarded.
REQ-026 rst SHALL override a simultaneous load.

Structure
REQ-027 TX and monitor state encodings and the 5-bit pattern constant 5'b10110 SHALL live in shared package pattern_pkg.
REQ-028 The monitor SHALL be sub-module pattern_tx_mon (inputs clk, rst, valid, out; output match_cnt).

Verification
REQ-029 DATA_W=8, GAP=0: load 8'hB6 -> out 1,0,1,1,0,1,1,0 on 8 consecutive valid cycles, match_cnt=1.
REQ-030 Loads 8'hB6 then 8'h5A back-to-back -> 16 contiguous valid cycles, no bubble, ready low while hold full.
REQ-031 GAP=2, two words -> exactly 2 valid=0 cycles between words.
REQ-032 load while ready=0 with data 8'hFF -> word dropped, stream unchanged.
REQ-033 rst asserted on bit 4 of a word -> next cycle valid=0, ready=1, match_cnt=0.
REQ-034 300 words of 8'hB6 -> match_cnt saturates at 255.
